iob_wstrb_byte_sequencer: RTL and testbench
===========================================

# iob_wstrb_byte_sequencer

Write-strobe byte sequencer: accepts one word-wide write (address, data, byte strobe) from an upstream native-style port and replays it as a sequence of single-byte writes on a byte-wide downstream port, lowest enabled byte lane first. It sequences the lowest-set-strobe-bit-to-byte-offset datapath, turning it into a multi-cycle controller. It sits between a word-wide master and byte-only peripherals or memories.

## Interface

- DATA_W, 32, upstream data width in bits. Must be a power of two, at least 16.
- ADDR_W, 32, byte address width for both ports.
- N, DATA_W/8, derived byte-lane count. Not overridable.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- s_valid_i  in  1  upstream write request valid.
- s_addr_i  in  ADDR_W  upstream byte address. The low $clog2(N) bits are ignored.
- s_wdata_i  in  DATA_W  upstream write data. Lane k is bits [8k+7:8k].
- s_wstrb_i  in  N  upstream byte strobe.
- s_ready_o  out  1  upstream request accepted this cycle when high together with s_valid_i.
- m_valid_o  out  1  downstream byte write valid.
- m_addr_o  out  ADDR_W  downstream byte address.
- m_wdata_o  out  8  downstream byte data.
- m_ready_i  in  1  downstream accepts the byte this cycle when high together with m_valid_o.
- done_o  out  1  one-cycle pulse: upstream request fully retired.
- busy_o  out  1  high while sub-writes are pending.

## Operation

- **Registers**
  - state: IDLE or ISSUE.
  - base_addr: ADDR_W bits, low $clog2(N) bits forced to 0.
  - data_q: DATA_W bits.
  - pend: N-bit pending-lane mask.
  - done_q: done pulse register.
- **IDLE**
  - s_ready_o=1, m_valid_o=0, busy_o=0.
  - On accept (s_valid_i & s_ready_o):
    - latch base_addr = s_addr_i with low bits cleared;
    - latch data_q = s_wdata_i;
    - latch pend = s_wstrb_i.
  - If s_wstrb_i is nonzero, go to ISSUE. If it is zero, stay in IDLE and set done_q for the next cycle. No downstream write is issued.
- **ISSUE**
  - s_ready_o=0, busy_o=1, m_valid_o=1.
  - off = index of the lowest set bit of pend, computed combinationally, $clog2(N) bits.
  - m_addr_o = base_addr | off. No carry, no overflow, because the base low bits are 0.
  - m_wdata_o = data_q[8*off+7 : 8*off].
  - On m_ready_i: clear pend[off].
    - If the cleared mask is all zero: go to IDLE and set done_q.
    - Otherwise stay in ISSUE; the next lane is presented in the following cycle.
  - Without m_ready_i: m_valid_o, m_addr_o and m_wdata_o hold stable. m_valid_o never drops before the handshake.
- done_o = done_q. It is high for exactly one cycle per accepted request.
- Upstream data/strobe changes after acceptance have no effect; all sub-writes use the latched values.
- **Reset:** rst_i sampled high at a clock edge sets state=IDLE, pend=0, base_addr=0, data_q=0, done_q=0. This applies in any state, including mid-sequence: pending lanes are discarded and no done pulse is produced.

## Timing

- **Reset values:**
  - s_ready_o=1, m_valid_o=0, busy_o=0, done_o=0;
  - m_addr_o=0, m_wdata_o=data_q[7:0]=0.
- **Accept to first downstream byte:** m_valid_o is high in cycle t+1 when the accept happens at the edge ending cycle t.
- **Per lane:** minimum one cycle with m_ready_i held high. Total ISSUE cycles = popcount(wstrb) plus stall cycles.
- **Done pulse:** done_o is high in the cycle after the last downstream handshake. s_ready_o is high in that same cycle, so back-to-back requests cost popcount+1 cycles each.
- **Zero strobe:** accepted in one cycle; done_o is high the next cycle; s_ready_o stays high.
- **Outputs:**
  - s_ready_o, m_valid_o and busy_o are decoded from state only; no combinational path from s_valid_i or m_ready_i.
  - m_addr_o and m_wdata_o depend on registers only.

## Test plan

- **Reset check:** hold rst_i for 2 cycles.
  - Required: s_ready_o=1, m_valid_o=0, busy_o=0, done_o=0.
- **Sparse strobe:** DATA_W=32, addr=0x1003, wdata=0xAABBCCDD, wstrb=4'b1010, m_ready_i=1.
  - Required: byte (0x1001, 0xCC), then (0x1003, 0xAA) in consecutive cycles.
  - done_o pulses 1 cycle after the second byte; s_ready_o returns high.
- **Backpressure:** wstrb=4'b1111, m_ready_i low 3 cycles on lane 2.
  - Required: lane 2 address/data held stable while m_valid_o stays high.
  - Lane order 0,1,2,3. Total ISSUE cycles = 7.
- **Zero strobe:** wstrb=0.
  - Required: accepted, no m_valid_o, done_o pulse the next cycle, back-to-back accept possible.
- **Reset mid-sequence:** wstrb=4'b1111, assert rst_i after lane 1 is accepted.
  - Required: next cycle IDLE, m_valid_o=0, no done_o.
  - The next request starts cleanly from its own lowest lane.
- **Back-to-back random:** DATA_W=64, 200 random requests with random m_ready_i.
  - Required: scoreboard matches every set lane exactly once, in ascending order, with correct address/data.
  - One done_o per request.

Source files
------------

// File: rtl/iob_wstrb_byte_sequencer.sv
// ---------------------------------------------------------------------------
// iob_wstrb_byte_sequencer
//
// Purpose:
//   Accepts one word-wide write (address, data, byte strobe) from an upstream
//   valid/ready port and replays it as a series of single-byte writes on a
//   byte-wide downstream port, lowest enabled byte lane first. A request
//   with an all-zero strobe is retired immediately without any downstream
//   traffic. done_o pulses once per retired request.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   s_valid_i  upstream request valid
//   s_addr_i   upstream byte address (low $clog2(N) bits ignored)
//   s_wdata_i  upstream write data, lane k = bits [8k+7:8k]
//   s_wstrb_i  upstream byte strobe
//   s_ready_o  upstream ready (high only while idle)
//   m_valid_o  downstream byte write valid
//   m_addr_o   downstream byte address
//   m_wdata_o  downstream byte data
//   m_ready_i  downstream ready
//   done_o     one-cycle pulse when a request is fully retired
//   busy_o     high while sub-writes are pending
// ---------------------------------------------------------------------------
module iob_wstrb_byte_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  input  logic [ADDR_W-1:0]     s_addr_i,
  input  logic [DATA_W-1:0]     s_wdata_i,
  input  logic [DATA_W/8-1:0]   s_wstrb_i,
  output logic                  s_ready_o,
  output logic                  m_valid_o,
  output logic [ADDR_W-1:0]     m_addr_o,
  output logic [7:0]            m_wdata_o,
  input  logic                  m_ready_i,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam int N     = DATA_W / 8;
  localparam int OFF_W = $clog2(N);

  // Clears the lane-offset bits of an address so base | off never carries.
  localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base_addr;
  logic [DATA_W-1:0]   r_data;
  logic [N-1:0]        r_pend;
  logic                r_done;

  logic [OFF_W-1:0]    w_off;
  logic [N-1:0]        w_lane_mask;
  logic [N-1:0]        w_pend_next;

  // Index of the lowest set bit; scanning downward lets the lowest hit win.
  function automatic logic [OFF_W-1:0] f_lowest_idx(input logic [N-1:0] mask);
    logic [OFF_W-1:0] idx;
    idx = {OFF_W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[k]) begin
        idx = OFF_W'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign w_off       = f_lowest_idx(r_pend);
  assign w_lane_mask = {{(N-1){1'b0}}, 1'b1} << w_off;
  assign w_pend_next = r_pend & ~w_lane_mask;

  // Control state, latched request and done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_base_addr <= {ADDR_W{1'b0}};
      r_data      <= {DATA_W{1'b0}};
      r_pend      <= {N{1'b0}};
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_valid_i) begin
            r_base_addr <= s_addr_i & BASE_MASK;
            r_data      <= s_wdata_i;
            r_pend      <= s_wstrb_i;
            if (|s_wstrb_i) begin
              r_state <= ST_ISSUE;
            end else begin
              // Empty strobe: nothing to replay, retire immediately.
              r_done <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (m_ready_i) begin
            r_pend <= w_pend_next;
            if (w_pend_next == {N{1'b0}}) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pend  <= {N{1'b0}};
        end
      endcase
    end
  end

  // Handshake outputs depend on the state register only.
  assign s_ready_o = (r_state == ST_IDLE);
  assign m_valid_o = (r_state == ST_ISSUE);
  assign busy_o    = (r_state == ST_ISSUE);
  assign done_o    = r_done;

  // Byte address/data come purely from registers, so they hold during stalls.
  assign m_addr_o  = r_base_addr | {{(ADDR_W-OFF_W){1'b0}}, w_off};
  assign m_wdata_o = r_data[{w_off, 3'b000} +: 8];

endmodule

// File: tb/tb_iob_wstrb_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_iob_wstrb_byte_sequencer
//
// Directed bench for iob_wstrb_byte_sequencer: a 32-bit instance exercises
// reset, sparse strobe, backpressure, zero strobe and mid-sequence reset; a
// 64-bit instance runs 200 back-to-back requests against a byte scoreboard.
// ---------------------------------------------------------------------------
module tb_iob_wstrb_byte_sequencer;

  logic        clk;
  logic        rst;

  // 32-bit instance
  logic        a_s_valid;
  logic [31:0] a_s_addr;
  logic [31:0] a_s_wdata;
  logic [3:0]  a_s_wstrb;
  logic        a_s_ready;
  logic        a_m_valid;
  logic [31:0] a_m_addr;
  logic [7:0]  a_m_wdata;
  logic        a_m_ready;
  logic        a_done;
  logic        a_busy;

  // 64-bit instance
  logic        b_s_valid;
  logic [31:0] b_s_addr;
  logic [63:0] b_s_wdata;
  logic [7:0]  b_s_wstrb;
  logic        b_s_ready;
  logic        b_m_valid;
  logic [31:0] b_m_addr;
  logic [7:0]  b_m_wdata;
  logic        b_m_ready;
  logic        b_done;
  logic        b_busy;

  int n_cmp = 0;
  int n_err = 0;

  iob_wstrb_byte_sequencer #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_valid_i (a_s_valid),
    .s_addr_i  (a_s_addr),
    .s_wdata_i (a_s_wdata),
    .s_wstrb_i (a_s_wstrb),
    .s_ready_o (a_s_ready),
    .m_valid_o (a_m_valid),
    .m_addr_o  (a_m_addr),
    .m_wdata_o (a_m_wdata),
    .m_ready_i (a_m_ready),
    .done_o    (a_done),
    .busy_o    (a_busy)
  );

  iob_wstrb_byte_sequencer #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_valid_i (b_s_valid),
    .s_addr_i  (b_s_addr),
    .s_wdata_i (b_s_wdata),
    .s_wstrb_i (b_s_wstrb),
    .s_ready_o (b_s_ready),
    .m_valid_o (b_m_valid),
    .m_addr_o  (b_m_addr),
    .m_wdata_o (b_m_wdata),
    .m_ready_i (b_m_ready),
    .done_o    (b_done),
    .busy_o    (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle32(input string tag);
    chk({tag, "_sready"}, 64'(a_s_ready), 64'(1'b1));
    chk({tag, "_mvalid"}, 64'(a_m_valid), 64'(1'b0));
    chk({tag, "_busy"},   64'(a_busy),    64'(1'b0));
  endtask

  task automatic chk_byte32(input string tag, input logic [31:0] addr, input logic [7:0] data);
    chk({tag, "_mvalid"}, 64'(a_m_valid), 64'(1'b1));
    chk({tag, "_sready"}, 64'(a_s_ready), 64'(1'b0));
    chk({tag, "_busy"},   64'(a_busy),    64'(1'b1));
    chk({tag, "_addr"},   64'(a_m_addr),  64'(addr));
    chk({tag, "_data"},   64'(a_m_wdata), 64'(data));
  endtask

  initial begin
    bit [31:0] q_addr[$];
    bit [7:0]  q_data[$];
    bit [31:0] r_addr;
    bit [7:0]  r_strb;
    int        cyc;
    int        sent;
    int        n_done;
    int        rem;
    logic      exp_done;
    logic      acc;

    rst = 1'b1;
    a_s_valid = 1'b0; a_s_addr = 32'h0; a_s_wdata = 32'h0; a_s_wstrb = 4'h0; a_m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_addr = 32'h0; b_s_wdata = 64'h0; b_s_wstrb = 8'h0; b_m_ready = 1'b0;

    // Reset held for two cycles.
    step();
    step();
    chk_idle32("rst");
    chk("rst_done",  64'(a_done),    64'(1'b0));
    chk("rst_addr",  64'(a_m_addr),  64'(32'h0));
    chk("rst_wdata", 64'(a_m_wdata), 64'(8'h0));
    chk("rst64_sready", 64'(b_s_ready), 64'(1'b1));
    chk("rst64_done",   64'(b_done),    64'(1'b0));
    rst = 1'b0;

    // Sparse strobe 4'b1010: lanes 1 then 3.
    a_s_valid = 1'b1; a_s_addr = 32'h0000_1003; a_s_wdata = 32'hAABB_CCDD;
    a_s_wstrb = 4'b1010; a_m_ready = 1'b1;
    step();
    a_s_valid = 1'b0; a_s_wdata = 32'h0; a_s_wstrb = 4'b0000;
    chk_byte32("sp_l1", 32'h0000_1001, 8'hCC);
    step();
    chk_byte32("sp_l3", 32'h0000_1003, 8'hAA);
    chk("sp_l3_done", 64'(a_done), 64'(1'b0));
    step();
    chk("sp_done", 64'(a_done), 64'(1'b1));
    chk_idle32("sp_end");
    step();
    chk("sp_done_clr", 64'(a_done), 64'(1'b0));

    // Backpressure: three stall cycles on lane 2, seven ISSUE cycles in all.
    a_s_valid = 1'b1; a_s_addr = 32'h0000_2000; a_s_wdata = 32'h4433_2211; a_s_wstrb = 4'b1111;
    step();
    a_s_valid = 1'b0;
    chk_byte32("bp_l0", 32'h0000_2000, 8'h11);
    step();
    chk_byte32("bp_l1", 32'h0000_2001, 8'h22);
    step();
    chk_byte32("bp_l2a", 32'h0000_2002, 8'h33);
    a_m_ready = 1'b0;
    step();
    chk_byte32("bp_l2b", 32'h0000_2002, 8'h33);
    step();
    chk_byte32("bp_l2c", 32'h0000_2002, 8'h33);
    step();
    chk_byte32("bp_l2d", 32'h0000_2002, 8'h33);
    a_m_ready = 1'b1;
    step();
    chk_byte32("bp_l3", 32'h0000_2003, 8'h44);
    chk("bp_l3_done", 64'(a_done), 64'(1'b0));
    step();
    chk("bp_done", 64'(a_done), 64'(1'b1));
    chk_idle32("bp_end");

    // Zero strobe twice back-to-back, then a one-lane request.
    a_s_valid = 1'b1; a_s_addr = 32'h0000_5000; a_s_wdata = 32'h1234_5678; a_s_wstrb = 4'b0000;
    step();
    chk("zs1_done", 64'(a_done), 64'(1'b1));
    chk_idle32("zs1");
    step();
    chk("zs2_done", 64'(a_done), 64'(1'b1));
    chk_idle32("zs2");
    a_s_addr = 32'h0000_5004; a_s_wdata = 32'h0000_00AB; a_s_wstrb = 4'b0001;
    step();
    a_s_valid = 1'b0;
    chk("zs3_done", 64'(a_done), 64'(1'b0));
    chk_byte32("zs3_l0", 32'h0000_5004, 8'hAB);
    step();
    chk("zs3_done_end", 64'(a_done), 64'(1'b1));

    // Reset in the middle of a full-strobe sequence.
    a_s_valid = 1'b1; a_s_addr = 32'h0000_3000; a_s_wdata = 32'h8877_6655; a_s_wstrb = 4'b1111;
    step();
    a_s_valid = 1'b0;
    chk_byte32("rm_l0", 32'h0000_3000, 8'h55);
    step();
    chk_byte32("rm_l1", 32'h0000_3001, 8'h66);
    step();
    chk_byte32("rm_l2", 32'h0000_3002, 8'h77);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle32("rm_rst");
    chk("rm_rst_done", 64'(a_done),    64'(1'b0));
    chk("rm_rst_addr", 64'(a_m_addr),  64'(32'h0));
    chk("rm_rst_data", 64'(a_m_wdata), 64'(8'h0));
    step();
    chk("rm_post_done", 64'(a_done), 64'(1'b0));
    chk_idle32("rm_post");
    a_s_valid = 1'b1; a_s_addr = 32'h0000_4001; a_s_wdata = 32'h00EE_0000; a_s_wstrb = 4'b0100;
    step();
    a_s_valid = 1'b0;
    chk_byte32("rm_new_l2", 32'h0000_4002, 8'hEE);
    step();
    chk("rm_new_done", 64'(a_done), 64'(1'b1));
    chk_idle32("rm_new_end");

    // 64-bit instance: 200 random requests with random downstream ready.
    cyc = 0; sent = 0; n_done = 0; rem = 0; exp_done = 1'b0;
    while ((sent < 200 || q_addr.size() != 0 || b_s_valid || exp_done) && cyc < 20000) begin
      chk("rnd_done",   64'(b_done),    64'(exp_done));
      chk("rnd_mvalid", 64'(b_m_valid), 64'(q_addr.size() != 0));
      chk("rnd_sready", 64'(b_s_ready), 64'(q_addr.size() == 0));
      if (b_done) n_done++;
      exp_done = 1'b0;
      if (!b_s_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
        b_s_addr  = $urandom;
        b_s_wdata = {$urandom, $urandom};
        b_s_wstrb = (sent % 16 == 5) ? 8'h00 : 8'($urandom_range(0, 255));
        b_s_valid = 1'b1;
        sent++;
      end
      b_m_ready = 1'($urandom_range(0, 1));
      if (b_m_valid && b_m_ready) begin
        if (q_addr.size() == 0) begin
          chk("rnd_unexpected_byte", 64'(b_m_addr), 64'(32'hFFFF_FFFF));
        end else begin
          chk("rnd_addr", 64'(b_m_addr),  64'(q_addr[0]));
          chk("rnd_data", 64'(b_m_wdata), 64'(q_data[0]));
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
          rem--;
          if (rem == 0) exp_done = 1'b1;
        end
      end
      acc = b_s_valid && b_s_ready;
      if (acc) begin
        r_addr = {b_s_addr[31:3], 3'b000};
        r_strb = b_s_wstrb;
        for (int k = 0; k < 8; k++) begin
          if (r_strb[k]) begin
            q_addr.push_back(r_addr | 32'(k));
            q_data.push_back(b_s_wdata[8*k +: 8]);
          end
        end
        rem = $countones(r_strb);
        if (r_strb == 8'h00) exp_done = 1'b1;
      end
      step();
      cyc++;
      if (acc) b_s_valid = 1'b0;
    end
    chk("rnd_timeout",    64'(cyc < 20000), 64'(1'b1));
    chk("rnd_done_count", 64'(n_done),      64'(200));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
